// File: rtl/etapa_mem.sv
`default_nettype none
// ============================================================================
// Module   : etapa_mem
// Brief    : MIPS MEM stage. Byte-addressed data memory with LB/LBU/LH/LHU/LW
//            loads and SB/SH/SW stores, the MEM/WB pipeline register, and a
//            combinational debug read port.
// Revision : 1.0 - initial release
// ============================================================================
module etapa_mem #(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_flush,
  input  logic [4:0]        i_write_reg,
  input  logic [31:0]       i_ALU_result,
  input  logic [31:0]       i_write_data,
  input  logic              i_MEM_read,
  input  logic              i_MEM_write,
  input  logic [1:0]        i_MEM_size,
  input  logic              i_MEM_unsigned,
  input  logic              i_WB_write,
  input  logic              i_WB_mem_to_reg,
  input  logic [ADDR_W-1:0] i_debug_addr,
  output logic [4:0]        o_write_reg,
  output logic [31:0]       o_ALU_result,
  output logic [31:0]       o_read_data,
  output logic              o_WB_write,
  output logic              o_WB_mem_to_reg,
  output logic              o_misaligned,
  output logic [31:0]       o_debug_data
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  // Data memory; intentionally not reset so contents survive a pipeline reset.
  logic [31:0] mem_q [MEM_WORDS];

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              size_bad;
  logic              access_mis;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_ext;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic              do_store;

  // Upper address bits are dropped so accesses wrap around the array.
  assign word_idx = i_ALU_result[ADDR_W+1:2];
  assign lane     = i_ALU_result[1:0];

  // Alignment check per access size; the reserved size is always rejected.
  always_comb begin
    size_bad = 1'b1;
    case (i_MEM_size)
      SZ_BYTE: size_bad = 1'b0;
      SZ_HALF: size_bad = lane[0];
      SZ_WORD: size_bad = |lane;
      default: size_bad = 1'b1;
    endcase
  end

  // Only real memory accesses can be flagged; ALU-only ops pass through clean.
  assign access_mis = (i_MEM_read | i_MEM_write) & size_bad;

  // Read path sees the pre-store contents of the array.
  assign rd_word = mem_q[word_idx];
  assign rd_byte = 8'(rd_word >> {lane, 3'b000});
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  // Extract and sign/zero-extend the load lane; non-loads and faults give 0.
  always_comb begin
    load_ext = 32'd0;
    if (i_MEM_read && !access_mis) begin
      case (i_MEM_size)
        SZ_BYTE: load_ext = {{24{~i_MEM_unsigned & rd_byte[7]}}, rd_byte};
        SZ_HALF: load_ext = {{16{~i_MEM_unsigned & rd_half[15]}}, rd_half};
        SZ_WORD: load_ext = rd_word;
        default: load_ext = 32'd0;
      endcase
    end
  end

  // Byte enables and lane-replicated store data for the write port.
  always_comb begin
    st_be   = 4'b0000;
    st_data = i_write_data;
    case (i_MEM_size)
      SZ_BYTE: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{i_write_data[7:0]}};
      end
      SZ_HALF: begin
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{i_write_data[15:0]}};
      end
      SZ_WORD: st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  assign do_store = i_MEM_write & i_enable & ~i_flush & ~i_reset & ~access_mis;

  // Byte-lane write into the data memory.
  always_ff @(posedge i_clk) begin
    if (do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) begin
          mem_q[word_idx][8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end
  end

  assign o_debug_data = mem_q[i_debug_addr];

  logic [4:0]  write_reg_q,   write_reg_d;
  logic [31:0] alu_q,         alu_d;
  logic [31:0] read_data_q,   read_data_d;
  logic        wb_write_q,    wb_write_d;
  logic        mem_to_reg_q,  mem_to_reg_d;
  logic        misaligned_q,  misaligned_d;

  // MEM/WB next state: stall holds, flush inserts a bubble, otherwise capture.
  always_comb begin
    write_reg_d  = write_reg_q;
    alu_d        = alu_q;
    read_data_d  = read_data_q;
    wb_write_d   = wb_write_q;
    mem_to_reg_d = mem_to_reg_q;
    misaligned_d = misaligned_q;
    if (i_enable) begin
      if (i_flush) begin
        write_reg_d  = 5'd0;
        alu_d        = 32'd0;
        read_data_d  = 32'd0;
        wb_write_d   = 1'b0;
        mem_to_reg_d = 1'b0;
        misaligned_d = 1'b0;
      end else begin
        write_reg_d  = i_write_reg;
        alu_d        = i_ALU_result;
        read_data_d  = load_ext;
        wb_write_d   = i_WB_write & ~access_mis;
        mem_to_reg_d = i_WB_mem_to_reg;
        misaligned_d = access_mis;
      end
    end
  end

  // MEM/WB register with asynchronous clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      write_reg_q  <= 5'd0;
      alu_q        <= 32'd0;
      read_data_q  <= 32'd0;
      wb_write_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      write_reg_q  <= write_reg_d;
      alu_q        <= alu_d;
      read_data_q  <= read_data_d;
      wb_write_q   <= wb_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign o_write_reg     = write_reg_q;
  assign o_ALU_result    = alu_q;
  assign o_read_data     = read_data_q;
  assign o_WB_write      = wb_write_q;
  assign o_WB_mem_to_reg = mem_to_reg_q;
  assign o_misaligned    = misaligned_q;

endmodule
`default_nettype wire

// File: tb/tb_etapa_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_etapa_mem
// Brief    : Self-checking bench for etapa_mem: byte-array reference model,
//            per-cycle compare, plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_etapa_mem;

  localparam int MEM_WORDS = 256;
  localparam int ADDR_W    = 8;
  localparam int NBYTES    = MEM_WORDS * 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b1;
  logic              fl = 1'b0;
  logic [4:0]        wreg = 5'd0;
  logic [31:0]       alu = 32'd0;
  logic [31:0]       wdata = 32'd0;
  logic              mrd = 1'b0;
  logic              mwr = 1'b0;
  logic [1:0]        msz = 2'b11;
  logic              muns = 1'b0;
  logic              wbw = 1'b0;
  logic              m2r = 1'b0;
  logic [ADDR_W-1:0] dbg_addr = '0;

  logic [4:0]  o_write_reg;
  logic [31:0] o_ALU_result;
  logic [31:0] o_read_data;
  logic        o_WB_write;
  logic        o_WB_mem_to_reg;
  logic        o_misaligned;
  logic [31:0] o_debug_data;

  int n_cmp = 0;
  int n_err = 0;

  etapa_mem #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_flush         (fl),
    .i_write_reg     (wreg),
    .i_ALU_result    (alu),
    .i_write_data    (wdata),
    .i_MEM_read      (mrd),
    .i_MEM_write     (mwr),
    .i_MEM_size      (msz),
    .i_MEM_unsigned  (muns),
    .i_WB_write      (wbw),
    .i_WB_mem_to_reg (m2r),
    .i_debug_addr    (dbg_addr),
    .o_write_reg     (o_write_reg),
    .o_ALU_result    (o_ALU_result),
    .o_read_data     (o_read_data),
    .o_WB_write      (o_WB_write),
    .o_WB_mem_to_reg (o_WB_mem_to_reg),
    .o_misaligned    (o_misaligned),
    .o_debug_data    (o_debug_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: flat byte array plus expected MEM/WB contents.
  logic [7:0]  m_mem   [NBYTES];
  bit          m_known [NBYTES];
  logic [4:0]  e_reg = 5'd0;
  logic [31:0] e_alu = 32'd0;
  logic [31:0] e_rd = 32'd0;
  bit          e_rd_known = 1'b1;
  logic        e_wbw = 1'b0;
  logic        e_m2r = 1'b0;
  logic        e_mis = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    int nb;
    int base;
    bit mis;
    bit kn;
    logic [31:0] v;
    if (rst) begin
      e_reg = 5'd0; e_alu = 32'd0; e_rd = 32'd0; e_rd_known = 1'b1;
      e_wbw = 1'b0; e_m2r = 1'b0; e_mis = 1'b0;
    end else if (en) begin
      base = int'(alu % 32'(NBYTES));
      case (msz)
        2'b00:   nb = 1;
        2'b01:   nb = 2;
        2'b11:   nb = 4;
        default: nb = 0;
      endcase
      mis = (mrd || mwr) && (nb == 0 || (base % nb) != 0);
      v = 32'd0;
      kn = 1'b1;
      if (mrd && !mis) begin
        for (int k = 0; k < nb; k++) begin
          v = v | (32'(m_mem[base + k]) << (8 * k));
          kn = kn & m_known[base + k];
        end
        if (!muns && nb < 4 && v[8 * nb - 1])
          v = v | ~((32'd1 << (8 * nb)) - 32'd1);
      end
      if (mwr && !fl && !mis) begin
        for (int k = 0; k < nb; k++) begin
          m_mem[base + k]   = 8'(wdata >> (8 * k));
          m_known[base + k] = 1'b1;
        end
      end
      if (fl) begin
        e_reg = 5'd0; e_alu = 32'd0; e_rd = 32'd0; e_rd_known = 1'b1;
        e_wbw = 1'b0; e_m2r = 1'b0; e_mis = 1'b0;
      end else begin
        e_reg = wreg; e_alu = alu; e_rd = v; e_rd_known = kn;
        e_wbw = wbw && !mis; e_m2r = m2r; e_mis = mis;
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-period.
  always @(negedge clk) begin : compare
    int db;
    bit dk;
    logic [31:0] dw;
    check("write_reg",  32'(o_write_reg), 32'(e_reg));
    check("alu_result", o_ALU_result, e_alu);
    check("wb_write",   32'(o_WB_write), 32'(e_wbw));
    check("mem_to_reg", 32'(o_WB_mem_to_reg), 32'(e_m2r));
    check("misaligned", 32'(o_misaligned), 32'(e_mis));
    if (e_rd_known) check("read_data", o_read_data, e_rd);
    db = int'(dbg_addr) * 4;
    dk = 1'b1;
    dw = 32'd0;
    for (int k = 0; k < 4; k++) begin
      dk = dk & m_known[db + k];
      dw = dw | (32'(m_mem[db + k]) << (8 * k));
    end
    if (dk) check("debug_data", o_debug_data, dw);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [4:0] r, input logic [31:0] a, input logic [31:0] d,
                    input logic rd, input logic wr, input logic [1:0] sz,
                    input logic uns, input logic w, input logic mr);
    wreg = r; alu = a; wdata = d; mrd = rd; mwr = wr; msz = sz;
    muns = uns; wbw = w; m2r = mr;
    cyc();
  endtask

  initial begin
    for (int i = 0; i < NBYTES; i++) begin
      m_mem[i] = 8'h00;
      m_known[i] = 1'b0;
    end
    #1 rst = 1'b1;
    #2;
    check("reset_alu",  o_ALU_result, 32'd0);
    check("reset_wbw",  32'(o_WB_write), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;

    // SW / LW round trip
    dbg_addr = 8'd4;
    op(5'd0, 32'h10, 32'hDEADBEEF, 0, 1, 2'b11, 0, 0, 0);
    op(5'd2, 32'h10, 32'h0,        1, 0, 2'b11, 0, 1, 0);
    check("lw_0x10", o_read_data, 32'hDEADBEEF);
    check("dbg_idx4", o_debug_data, 32'hDEADBEEF);

    // SB then byte/word loads
    op(5'd0, 32'h20, 32'h0,  0, 1, 2'b11, 0, 0, 0);
    op(5'd0, 32'h21, 32'h80, 0, 1, 2'b00, 0, 0, 0);
    op(5'd3, 32'h21, 32'h0,  1, 0, 2'b00, 0, 1, 0);
    check("lb_0x21", o_read_data, 32'hFFFFFF80);
    op(5'd3, 32'h21, 32'h0,  1, 0, 2'b00, 1, 1, 0);
    check("lbu_0x21", o_read_data, 32'h00000080);
    op(5'd3, 32'h20, 32'h0,  1, 0, 2'b11, 0, 1, 0);
    check("lw_0x20", o_read_data, 32'h00008000);

    // SH then halfword/word loads
    op(5'd0, 32'h30, 32'h0,    0, 1, 2'b11, 0, 0, 0);
    op(5'd0, 32'h32, 32'h8001, 0, 1, 2'b01, 0, 0, 0);
    op(5'd4, 32'h32, 32'h0,    1, 0, 2'b01, 0, 1, 0);
    check("lh_0x32", o_read_data, 32'hFFFF8001);
    op(5'd4, 32'h32, 32'h0,    1, 0, 2'b01, 1, 1, 0);
    check("lhu_0x32", o_read_data, 32'h00008001);
    op(5'd4, 32'h30, 32'h0,    1, 0, 2'b11, 0, 1, 0);
    check("lw_0x30", o_read_data, 32'h80010000);

    // Misaligned store and load
    dbg_addr = 8'h10;
    op(5'd0, 32'h40, 32'h11223344, 0, 1, 2'b11, 0, 0, 0);
    op(5'd5, 32'h41, 32'hFFFFFFFF, 0, 1, 2'b11, 0, 1, 0);
    check("sw_mis_flag", 32'(o_misaligned), 32'd1);
    check("sw_mis_wbw",  32'(o_WB_write), 32'd0);
    check("sw_mis_mem",  o_debug_data, 32'h11223344);
    op(5'd6, 32'h43, 32'h0, 1, 0, 2'b01, 0, 1, 0);
    check("lh_mis_data", o_read_data, 32'd0);
    check("lh_mis_flag", 32'(o_misaligned), 32'd1);
    op(5'd6, 32'h40, 32'h0, 1, 0, 2'b10, 0, 1, 0);
    check("size10_mis", 32'(o_misaligned), 32'd1);

    // R-type passthrough
    dbg_addr = 8'd4;
    op(5'd7, 32'h12345678, 32'h0, 0, 0, 2'b11, 0, 1, 1);
    check("rtype_alu", o_ALU_result, 32'h12345678);
    check("rtype_wbw", 32'(o_WB_write), 32'd1);

    // Stall: store suppressed, outputs hold
    en = 1'b0;
    op(5'd8, 32'h10, 32'hCAFEF00D, 0, 1, 2'b11, 0, 1, 0);
    check("stall_reg", 32'(o_write_reg), 32'd7);
    check("stall_alu", o_ALU_result, 32'h12345678);
    check("stall_mem", o_debug_data, 32'hDEADBEEF);
    fl = 1'b1;
    op(5'd8, 32'h10, 32'hCAFEF00D, 0, 1, 2'b11, 0, 1, 0);
    check("stall_flush_alu", o_ALU_result, 32'h12345678);
    en = 1'b1;

    // Flush: bubble and no store
    op(5'd9, 32'h10, 32'h55555555, 0, 1, 2'b11, 0, 1, 1);
    check("flush_alu", o_ALU_result, 32'd0);
    check("flush_reg", 32'(o_write_reg), 32'd0);
    check("flush_mem", o_debug_data, 32'hDEADBEEF);
    fl = 1'b0;

    // Load and store together: load sees pre-store data
    op(5'd10, 32'h10, 32'hA5A5A5A5, 1, 1, 2'b11, 0, 1, 0);
    check("rdwr_read", o_read_data, 32'hDEADBEEF);
    check("rdwr_mem",  o_debug_data, 32'hA5A5A5A5);

    // Asynchronous reset mid-stream
    op(5'd11, 32'hFFFF0000, 32'h0, 0, 0, 2'b11, 0, 1, 1);
    rst = 1'b1;
    #1;
    check("async_rst_alu", o_ALU_result, 32'd0);
    check("async_rst_reg", 32'(o_write_reg), 32'd0);
    check("async_rst_wbw", 32'(o_WB_write), 32'd0);
    #1 rst = 1'b0;
    op(5'd12, 32'h10, 32'h0, 1, 0, 2'b11, 0, 1, 0);
    check("lw_after_rst", o_read_data, 32'hA5A5A5A5);
    op(5'd12, 32'h410, 32'h0, 1, 0, 2'b11, 0, 1, 0);
    check("lw_wrap", o_read_data, 32'hA5A5A5A5);

    op(5'd0, 32'h0, 32'h0, 0, 0, 2'b11, 0, 0, 0);
    cyc();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
